// File: rtl/vme_reg_slave.sv
// A16/D16 VME register slave: 2-FF strobe synchronisers, five-state handshake FSM, NUM_RW writable
// registers, read-only inputs and a status/ID word. Define VME_SLAVE_BERR_EN to enable bus-error replies.
`timescale 1ns/1ps

module vme_reg_slave #(
    parameter logic [15:0] BASE_ADDR = 16'h7C80,
    parameter int          NUM_REGS  = 16,
    parameter int          NUM_RW    = 8,
    parameter logic [15:0] STATUSID  = 16'hA800
) (
    input  logic                                   I_CLK_32M,
    input  logic                                   I_VME_SYSRESET,
    input  logic                                   I_VME_AS,
    input  logic                                   I_VME_DS0,
    input  logic                                   I_VME_DS1,
    input  logic                                   I_VME_WR,
    input  logic                                   I_VME_LWORD,
    input  logic [15:1]                            I_VME_A,
    input  logic [5:0]                             I_VME_AM,
    input  logic [15:0]                            I_VME_D,
    output logic [15:0]                            O_VME_D,
    output logic                                   O_VME_D_OE,
    output logic                                   O_VME_DTACK_D,
    output logic                                   O_VME_DTACK_EN,
    output logic                                   O_VME_BERR,
    output logic [16*NUM_RW-1:0]                   O_REGS,
    input  logic [16*(NUM_REGS-NUM_RW-1)-1:0]      I_RO_DATA,
    output logic                                   O_WR_STB,
    output logic                                   O_RD_STB,
    output logic [$clog2(NUM_REGS)-1:0]            O_IDX
);

    localparam int IW     = $clog2(NUM_REGS);
    localparam int NUM_RO = NUM_REGS - NUM_RW - 1;

    typedef enum logic [2:0] {
        IDLE,
        SKEW,
        DECODE,
        ACK,
        RELEASE
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          w_latch;
    logic          w_ack_entry;

    logic [3:0]    r_sync1;
    logic [3:0]    r_sync2;
    logic          w_as_s;
    logic          w_ds0_s;
    logic          w_ds1_s;
    logic          w_wr_s;
    logic          w_ds_idle;

    logic          r_armed;
    logic          r_hit;
    logic          r_wr_lat;
    logic          r_lane_hi;
    logic          r_lane_lo;
    logic [15:0]   r_d_lat;
    logic [IW-1:0] r_idx;

    logic [15:0]   r_regs [NUM_RW];
    logic [15:0]   w_rdata;
    logic [15:0]   r_rdata;
    logic          r_oe;
    logic          r_dtack_d;
    logic          r_dtack_en;
    logic          r_wr_stb;
    logic          r_rd_stb;

    logic          w_am_ok;
    logic          w_in_win;
    logic          w_hit;
    logic          w_unused;

    // Strobe pins are asynchronous; bit order {WR, DS1, DS0, AS}, idle level is high.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge I_CLK_32M) begin
        if (I_VME_SYSRESET) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= {I_VME_WR, I_VME_DS1, I_VME_DS0, I_VME_AS};
            r_sync2 <= r_sync1;
        end
    end

    assign w_as_s    = r_sync2[0];
    assign w_ds0_s   = r_sync2[1];
    assign w_ds1_s   = r_sync2[2];
    assign w_wr_s    = r_sync2[3];
    assign w_ds_idle = w_ds0_s & w_ds1_s;

    // BASE_ADDR is window-aligned, so (A - BASE_ADDR) >> 1 reduces to the low address bits.
    assign w_am_ok  = (I_VME_AM == 6'h29) || (I_VME_AM == 6'h2D);
    assign w_in_win = (I_VME_A[15:IW+1] == BASE_ADDR[15:IW+1]);
    assign w_hit    = w_am_ok && w_in_win;
    assign w_unused = I_VME_LWORD;

    always_ff @(posedge I_CLK_32M) begin
        if (I_VME_SYSRESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        w_next      = r_state;
        w_latch     = 1'b0;
        w_ack_entry = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_armed && !w_as_s && (!w_ds0_s || !w_ds1_s)) begin
                    w_next = SKEW;
                end
            end
            SKEW: begin
                if (w_as_s) begin
                    w_next = IDLE;
                end else begin
                    w_next  = DECODE;
                    w_latch = 1'b1;
                end
            end
            DECODE: begin
                if (w_as_s || !r_hit) begin
                    w_next = IDLE;
                end else begin
                    w_next      = ACK;
                    w_ack_entry = 1'b1;
                end
            end
            ACK: begin
                if (w_ds_idle) begin
                    w_next = RELEASE;
                end
            end
            RELEASE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Address phase capture on DECODE entry; r_armed forces AS high between cycles.
    always_ff @(posedge I_CLK_32M) begin
        if (I_VME_SYSRESET) begin
            r_armed   <= 1'b0;
            r_hit     <= 1'b0;
            r_wr_lat  <= 1'b0;
            r_lane_hi <= 1'b0;
            r_lane_lo <= 1'b0;
            r_d_lat   <= '0;
            r_idx     <= '0;
        end else begin
            if (r_state != IDLE && w_next == IDLE) begin
                r_armed <= 1'b0;
            end else if (r_state == IDLE && w_as_s) begin
                r_armed <= 1'b1;
            end
            if (w_latch) begin
                r_hit     <= w_hit;
                r_wr_lat  <= !w_wr_s;
                r_lane_hi <= !w_ds1_s;
                r_lane_lo <= !w_ds0_s;
                r_d_lat   <= I_VME_D;
                r_idx     <= I_VME_A[IW:1];
            end
        end
    end

    // NOTE: the register file is small flops, not RAM, so it is reset to give O_REGS a defined value.
    always_ff @(posedge I_CLK_32M) begin
        if (I_VME_SYSRESET) begin
            for (int i = 0; i < NUM_RW; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_ack_entry && r_wr_lat) begin
            for (int i = 0; i < NUM_RW; i++) begin
                if (r_idx == IW'(i)) begin
                    if (r_lane_hi) r_regs[i][15:8] <= r_d_lat[15:8];
                    if (r_lane_lo) r_regs[i][7:0]  <= r_d_lat[7:0];
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_RW; g++) begin : g_regs_out
        assign O_REGS[16*g +: 16] = r_regs[g];
    end

    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < NUM_RW; i++) begin
            if (r_idx == IW'(i)) w_rdata = r_regs[i];
        end
        for (int i = 0; i < NUM_RO; i++) begin
            if (r_idx == IW'(NUM_RW + i)) w_rdata = I_RO_DATA[16*i +: 16];
        end
        if (r_idx == IW'(NUM_REGS - 1)) w_rdata = STATUSID;
    end

    // Bus-facing outputs are registered from the next state so the drivers never glitch.
    always_ff @(posedge I_CLK_32M) begin
        if (I_VME_SYSRESET) begin
            r_dtack_en <= 1'b0;
            r_dtack_d  <= 1'b1;
            r_oe       <= 1'b0;
            r_wr_stb   <= 1'b0;
            r_rd_stb   <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_dtack_en <= (w_next == ACK) || (w_next == RELEASE);
            r_dtack_d  <= (w_next != ACK);
            r_oe       <= (w_next == ACK) && !r_wr_lat;
            r_wr_stb   <= w_ack_entry && r_wr_lat;
            r_rd_stb   <= w_ack_entry && !r_wr_lat;
            if (w_ack_entry && !r_wr_lat) begin
                r_rdata <= w_rdata;
            end
        end
    end

`ifdef VME_SLAVE_BERR_EN
    logic w_berr_hit;
    logic r_berr;

    assign w_berr_hit = w_am_ok && !w_in_win && (I_VME_A[15:8] == BASE_ADDR[15:8]);

    // Held from DECODE entry until the master lifts both data strobes.
    always_ff @(posedge I_CLK_32M) begin
        if (I_VME_SYSRESET) begin
            r_berr <= 1'b0;
        end else if (w_latch && w_berr_hit) begin
            r_berr <= 1'b1;
        end else if (w_ds_idle) begin
            r_berr <= 1'b0;
        end
    end

    assign O_VME_BERR = r_berr;
`else
    assign O_VME_BERR = 1'b0;
`endif

    assign O_VME_D        = r_rdata;
    assign O_VME_D_OE     = r_oe;
    assign O_VME_DTACK_D  = r_dtack_d;
    assign O_VME_DTACK_EN = r_dtack_en;
    assign O_WR_STB       = r_wr_stb;
    assign O_RD_STB       = r_rd_stb;
    assign O_IDX          = r_idx;

endmodule

// File: doc/vme_reg_slave.md
VME_REG_SLAVE -- requirements
Module: vme_reg_slave

Interface
REQ-001 SHALL provide parameter BASE_ADDR, default 16'h7C80, A16 byte address of register 0; aligned to 2*NUM_REGS.
REQ-002 SHALL provide parameter NUM_REGS, default 16, total 16-bit registers in window; power of 2, 2..128.
REQ-003 SHALL provide parameter NUM_RW, default 8, count of writable registers (indices 0..NUM_RW-1); the rest are read-only.
REQ-004 SHALL provide parameter STATUSID, default 16'hA800, value returned at index NUM_REGS-1.
REQ-005 SHALL have one clock and a synchronous, active-high reset.
REQ-006 Ports:
- I_CLK_32M  in  1  system clock.
- I_VME_SYSRESET  in  1  synchronous active-high reset.
- I_VME_AS, I_VME_DS0, I_VME_DS1, I_VME_WR  in  1 each  VME strobes, active low, asynchronous.
- I_VME_LWORD  in  1  VME LWORD.
- I_VME_A  in  [15:1]  VME address.
- I_VME_AM  in  [5:0]  address modifier.
- I_VME_D  in  [15:0]  bus data in.
- O_VME_D  out  [15:0]  read data.
- O_VME_D_OE  out  1  data driver enable.
- O_VME_DTACK_D  out  1  DTACK level, 0 = asserted.
- O_VME_DTACK_EN  out  1  DTACK driver enable.
- O_VME_BERR  out  1  bus error, active high to the external driver.
- O_REGS  out  [16*NUM_RW-1:0]  writable register contents, register i at [16i+15:16i].
- I_RO_DATA  in  [16*(NUM_REGS-NUM_RW-1)-1:0]  read-only register values.
- O_WR_STB, O_RD_STB  out  1 each  one-cycle access pulses.
- O_IDX  out  [$clog2(NUM_REGS)-1:0]  register index of the current access.

Function
REQ-007 SHALL pass AS, DS0, DS1 and WR through 2-FF synchronisers; all decisions SHALL use the synchronised copies.
REQ-008 FSM states SHALL be IDLE, SKEW, DECODE, ACK, RELEASE.
REQ-009 IDLE->SKEW SHALL occur when AS is low and at least one DS is low; SKEW SHALL last 1 cycle to absorb DS0/DS1 skew.
REQ-010 DECODE SHALL latch A, AM, lanes (DS1 low = D[15:8], DS0 low = D[7:0]), WR and D.
- hit = AM in {0x29, 0x2D} and A[15:1] inside the window.
- index = (A - BASE_ADDR) >> 1.
REQ-011 On hit, DECODE->ACK. In ACK:
- DTACK_EN=1, DTACK_D=0.
- Write to index < NUM_RW: enabled lanes SHALL update in the ACK entry cycle.
- Write to a read-only index: no update, still acknowledged.
- Read: O_VME_D SHALL hold the registered value and O_VME_D_OE=1.
- O_WR_STB or O_RD_STB SHALL pulse in the ACK entry cycle.
REQ-012 DTACK_D SHALL assert exactly 4 clocks after the first pin-level DS fall.
REQ-013 ACK->RELEASE SHALL occur when both DS are high.
- RELEASE SHALL drive DTACK_D=1 with DTACK_EN=1 and OE=0 for 1 cycle, then go to IDLE.
- IDLE SHALL require AS high before a new access can start.
REQ-014 On a miss, DECODE->IDLE with no response.
REQ-015 Abort: if AS rises in SKEW or DECODE, the FSM SHALL return to IDLE with no write and no strobe.
REQ-016 O_IDX SHALL hold the latched index from DECODE until the next DECODE.

Reset
REQ-017 On reset the FSM SHALL go to IDLE, regardless of the current state, at the next edge.
REQ-018 Reset values: DTACK_EN=0, DTACK_D=1, OE=0, BERR=0, strobes=0, O_IDX=0, O_REGS=0, synchronisers=1.

Configuration
REQ-019 Macro VME_SLAVE_BERR_EN:
- Defined: an A16 AM hit outside the window whose A[15:8] equals BASE_ADDR[15:8] SHALL assert O_VME_BERR from DECODE until both DS are high, then release.
- Undefined: O_VME_BERR SHALL be tied 0 and such accesses SHALL behave as misses.

Verification
REQ-020 Write 0x1234 to 0x7C82 (AM 0x29, both DS) -> DTACK at clock 4, O_REGS[31:16]=0x1234, one O_WR_STB with O_IDX=1.
REQ-021 Byte write 0xAB55 with DS0 only to 0x7C80 (reg 0 = 0x1111) -> reg 0 = 0x1155.
REQ-022 Read 0x7C9E -> O_VME_D=0xA800, OE=1 until DS rises; DTACK high for 1 cycle, then EN=0.
REQ-023 AM 0x3D or address 0x7D00 -> no DTACK, no strobe; with VME_SLAVE_BERR_EN, address 0x7CC0 -> BERR until DS rises.
REQ-024 Reset asserted in ACK -> next edge IDLE, DTACK_EN=0, O_REGS=0; AS rise in SKEW -> no write.
